// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared CPU-side types.
//   word_t      : 32-bit data/address word
//   ramstate_t  : RAM responder status seen by the requester
//   RAM_LAT     : default number of BUSY cycles per RAM access
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    localparam int RAM_LAT = 2;

endpackage

// File: rtl/ram_array.sv
// ram_array -- 2**DEPTH_W x 32 word storage, synchronous write, asynchronous read.
// Contents are not reset.
//   clk   : clock
//   we    : write enable (write on rising edge)
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : read data (combinational)
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [DEPTH_W-1:0] waddr,
    input  word_t              wdata,
    input  logic [DEPTH_W-1:0] raddr,
    output word_t              rdata
);

    word_t mem [0:(1 << DEPTH_W) - 1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_responder.sv
// ram_responder -- fixed-latency RAM model answering a held read/write request.
// A legal request sees FREE, then LAT cycles of BUSY, then one ACCESS cycle.
// Illegal requests (both REN/WEN, index out of range) park in ERROR until
// the requester drops everything.
//   CLK      : clock
//   nRST     : synchronous active-low reset
//   ramREN   : read request (held until ACCESS)
//   ramWEN   : write request (held until ACCESS)
//   ramaddr  : byte address, word index = ramaddr[DEPTH_W+1:2]
//   ramstore : write data
//   ramload  : read data, nonzero only in the ACCESS cycle of a read
//   ramstate : FREE/BUSY/ACCESS/ERROR
// Optional macro RAM_RESP_ALIGN_CHECK_EN: misaligned addresses (ramaddr[1:0]!=0)
// are treated as illegal requests.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT     = RAM_LAT,
    parameter int DEPTH_W = 8
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, FAULT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t state, next;
    logic [3:0] cnt;
    logic       wr_q;
    word_t      addr_q;
    word_t      store_q;
    word_t      rdata;

    logic req, bad, out_of_range, misalign;
    logic load, dec, rd_hit, we;

    assign req          = ramREN ^ ramWEN;
    assign out_of_range = |(ramaddr >> (DEPTH_W + 2));
`ifdef RAM_RESP_ALIGN_CHECK_EN
    assign misalign     = |ramaddr[1:0];
`else
    assign misalign     = 1'b0;
`endif
    assign bad = (ramREN & ramWEN) | (req & (out_of_range | misalign));

    always_ff @(posedge CLK) begin
        if (!nRST) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        load = 1'b0;
        dec  = 1'b0;
        case (state)
            IDLE: begin
                if (bad) next = FAULT;
                else if (req) begin
                    next = WAIT;
                    load = 1'b1;
                end
            end
            WAIT: begin
                if (bad)       next = FAULT;
                else if (!req) next = IDLE;
                // a different legal request restarts the full latency
                else if (ramWEN != wr_q || ramaddr != addr_q) load = 1'b1;
                else if (cnt == 4'd0) next = DONE;
                else dec = 1'b1;
            end
            DONE:  next = IDLE;
            FAULT: if (!ramREN && !ramWEN) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        case (state)
            IDLE:    ramstate = FREE;
            WAIT:    ramstate = BUSY;
            DONE:    ramstate = ACCESS;
            default: ramstate = ERROR;
        endcase
    end

    assign rd_hit = (state == WAIT) && (next == DONE) && !wr_q;
    // reset in DONE drops the pending write
    assign we     = (state == DONE) && wr_q && nRST;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            ramload <= '0;
        end else begin
            ramload <= rd_hit ? rdata : '0;
            if (load) begin
                wr_q    <= ramWEN;
                addr_q  <= ramaddr;
                store_q <= ramstore;
                cnt     <= CNT_INIT;
            end else if (dec) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    ram_array #(.DEPTH_W(DEPTH_W)) u_array (
        .clk   (CLK),
        .we    (we),
        .waddr (addr_q[DEPTH_W+1:2]),
        .wdata (store_q),
        .raddr (addr_q[DEPTH_W+1:2]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder -- directed bench for ram_responder (LAT=2, DEPTH_W=8).
// A transaction-level model predicts ramstate/ramload every cycle; directed
// scenarios also pin key cycles with literal expectations.
module tb_ram_responder;
    import cpu_types_pkg::*;

    localparam int LAT     = 2;
    localparam int DEPTH_W = 8;

    logic      CLK = 1'b0;
    logic      nRST = 1'b0;
    logic      ramREN = 1'b0;
    logic      ramWEN = 1'b0;
    word_t     ramaddr = '0;
    word_t     ramstore = '0;
    word_t     ramload;
    ramstate_t ramstate;

    ram_responder #(.LAT(LAT), .DEPTH_W(DEPTH_W)) dut (
        .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // ---------------- model ----------------
    ramstate_t m_st = FREE;
    int        m_left = 0;
    bit        m_wr = 1'b0;
    word_t     m_addr = '0;
    word_t     m_data = '0;
    word_t     m_mem [int];

    function automatic bit m_bad(bit r, bit w, word_t a);
        bit b;
        b = r && w;
        if (r != w) begin
            if (a >= (32'd4 << DEPTH_W)) b = 1'b1;
`ifdef RAM_RESP_ALIGN_CHECK_EN
            if (a % 4 != 0) b = 1'b1;
`endif
        end
        return b;
    endfunction

    always @(posedge CLK) begin : model
        bit r, w, q, b;
        r = ramREN; w = ramWEN; q = (r != w); b = m_bad(r, w, ramaddr);
        if (!nRST) begin
            m_st = FREE; m_left = 0;
        end else begin
            case (m_st)
                FREE: begin
                    if (b) m_st = ERROR;
                    else if (q) begin
                        m_wr = w; m_addr = ramaddr; m_data = ramstore;
                        m_left = LAT; m_st = BUSY;
                    end
                end
                BUSY: begin
                    if (b) m_st = ERROR;
                    else if (!q) m_st = FREE;
                    else if (w != m_wr || ramaddr != m_addr) begin
                        m_wr = w; m_addr = ramaddr; m_data = ramstore; m_left = LAT;
                    end else begin
                        m_left--;
                        if (m_left == 0) m_st = ACCESS;
                    end
                end
                ACCESS: begin
                    if (m_wr) m_mem[int'(m_addr >> 2)] = m_data;
                    m_st = FREE;
                end
                ERROR: if (!r && !w) m_st = FREE;
                default: m_st = FREE;
            endcase
        end
    end

    always @(negedge CLK) begin : compare
        bit    known;
        word_t exp;
        if (chk_en) begin
            checks++;
            if (ramstate !== m_st) begin
                failures++;
                $display("FAIL state t=%0t: got %0d want %0d", $time, ramstate, m_st);
            end
            known = 1'b1; exp = '0;
            if (m_st == ACCESS && !m_wr) begin
                if (m_mem.exists(int'(m_addr >> 2))) exp = m_mem[int'(m_addr >> 2)];
                else known = 1'b0;
            end
            if (known) begin
                checks++;
                if (ramload !== exp) begin
                    failures++;
                    $display("FAIL ramload t=%0t: got %h want %h", $time, ramload, exp);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic lit_state(input string nm, input ramstate_t exp);
        checks++;
        if (ramstate !== exp) begin
            failures++;
            $display("FAIL %s: got state %0d want %0d", nm, ramstate, exp);
        end
    endtask

    task automatic lit_word(input string nm, input word_t got, input word_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // present a request, wait (bounded) for ACCESS, drop it, return to FREE
    task automatic access(input bit r, input bit w, input word_t a, input word_t d,
                          output word_t got);
        bit seen;
        ramREN = r; ramWEN = w; ramaddr = a; ramstore = d;
        got = '0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ramstate == ACCESS) begin
                got = ramload; seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL access_timeout addr=%h: got no ACCESS want ACCESS", a);
        end
        ramREN = 1'b0; ramWEN = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        word_t got;
        nRST = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        lit_state("reset_state", FREE);
        lit_word("reset_load", ramload, 32'h0);
        nRST = 1'b1;
        tick();

        // write 0xDEADBEEF to 0x40 then read it back
        ramWEN = 1'b1; ramaddr = 32'h40; ramstore = 32'hDEADBEEF;
        lit_state("w40_c0", FREE);
        tick(); lit_state("w40_c1", BUSY);
        tick(); lit_state("w40_c2", BUSY);
        tick(); lit_state("w40_c3", ACCESS); lit_word("w40_load", ramload, 32'h0);
        ramWEN = 1'b0;
        tick(); lit_state("w40_c4", FREE);
        ramREN = 1'b1; ramaddr = 32'h40;
        lit_state("r40_c0", FREE);
        tick(); lit_state("r40_c1", BUSY); lit_word("r40_busy_load", ramload, 32'h0);
        tick(); lit_state("r40_c2", BUSY);
        tick(); lit_state("r40_c3", ACCESS); lit_word("r40_load", ramload, 32'hDEADBEEF);
        ramREN = 1'b0;
        tick(); lit_state("r40_c4", FREE); lit_word("r40_after_load", ramload, 32'h0);

        // preload
        access(1'b0, 1'b1, 32'h10, 32'h11111111, got);
        access(1'b0, 1'b1, 32'h14, 32'h22222222, got);
        access(1'b0, 1'b1, 32'h80, 32'hCAFEF00D, got);
        access(1'b0, 1'b1, 32'h20, 32'h0BADF00D, got);
        access(1'b0, 1'b1, 32'h00, 32'h01234567, got);

        // address change during WAIT restarts latency
        ramREN = 1'b1; ramaddr = 32'h10;
        tick(); lit_state("chg_c1", BUSY);
        ramaddr = 32'h14;
        tick(); lit_state("chg_c2", BUSY);
        tick(); lit_state("chg_c3", BUSY);
        tick(); lit_state("chg_c4", ACCESS); lit_word("chg_load", ramload, 32'h22222222);
        ramREN = 1'b0;
        tick();

        // op change (write->read) during WAIT: no write performed
        ramWEN = 1'b1; ramaddr = 32'h14; ramstore = 32'h0;
        tick();
        access(1'b1, 1'b0, 32'h14, 32'h0, got);
        lit_word("opchg_load", got, 32'h22222222);

        // aborted write leaves storage unchanged
        ramWEN = 1'b1; ramaddr = 32'h80; ramstore = 32'hFFFFFFFF;
        tick(); lit_state("abort_c1", BUSY);
        ramWEN = 1'b0;
        tick(); lit_state("abort_c2", FREE);
        access(1'b1, 1'b0, 32'h80, 32'h0, got);
        lit_word("abort_read", got, 32'hCAFEF00D);

        // held request: one FREE bubble then a new access
        ramREN = 1'b1; ramaddr = 32'h10;
        tick(); tick(); tick();
        lit_state("held_acc", ACCESS); lit_word("held_load", ramload, 32'h11111111);
        tick(); lit_state("held_bubble", FREE);
        tick(); lit_state("held_restart", BUSY);
        ramREN = 1'b0;
        tick(); lit_state("held_drop", FREE);

        // both REN and WEN -> ERROR until both drop
        ramREN = 1'b1; ramWEN = 1'b1; ramaddr = 32'h0; ramstore = 32'hFFFFFFFF;
        tick(); lit_state("both_c1", ERROR);
        ramWEN = 1'b0;
        tick(); lit_state("both_c2", ERROR);
        ramREN = 1'b0;
        tick(); lit_state("both_c3", FREE);
        access(1'b1, 1'b0, 32'h0, 32'h0, got);
        lit_word("both_read", got, 32'h01234567);

        // out-of-range index and top legal index
        ramREN = 1'b1; ramaddr = 32'h400;
        tick(); lit_state("oor_c1", ERROR);
        ramREN = 1'b0;
        tick(); lit_state("oor_c2", FREE);
        access(1'b0, 1'b1, 32'h3FC, 32'h5A5A0001, got);
        access(1'b1, 1'b0, 32'h3FC, 32'h0, got);
        lit_word("top_read", got, 32'h5A5A0001);

        // misaligned address
`ifdef RAM_RESP_ALIGN_CHECK_EN
        ramREN = 1'b1; ramaddr = 32'h42;
        tick(); lit_state("mis_c1", ERROR);
        ramREN = 1'b0;
        tick(); lit_state("mis_c2", FREE);
`else
        access(1'b1, 1'b0, 32'h42, 32'h0, got);
        lit_word("mis_read", got, 32'hDEADBEEF);
`endif

        // reset during DONE of a write discards it
        ramWEN = 1'b1; ramaddr = 32'h20; ramstore = 32'h55AA55AA;
        tick(); tick(); tick();
        lit_state("rstd_acc", ACCESS);
        nRST = 1'b0;
        tick(); lit_state("rstd_free", FREE);
        nRST = 1'b1; ramWEN = 1'b0;
        tick();
        access(1'b1, 1'b0, 32'h20, 32'h0, got);
        lit_word("rstd_read", got, 32'h0BADF00D);

        // reset during WAIT of a write discards it
        ramWEN = 1'b1; ramaddr = 32'h14; ramstore = 32'h99;
        tick(); lit_state("rstw_busy", BUSY);
        nRST = 1'b0; ramWEN = 1'b0;
        tick(); lit_state("rstw_free", FREE);
        nRST = 1'b1;
        tick();
        access(1'b1, 1'b0, 32'h14, 32'h0, got);
        lit_word("rstw_read", got, 32'h22222222);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
